// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the ROM read bus and the instruction hand-off of instr_fetch.
//
//   ROM bus         : rom_addr[5:0], rom_read, rom_ena (fetch -> ROM),
//                     rom_data[7:0] (ROM -> fetch)
//   Instruction out : instr[7:0], opcode[1:0], operand[5:0], instr_valid
//                     (fetch -> consumer), instr_ready (consumer -> fetch)
//   Jump request    : jump_en, jump_addr[5:0] (consumer -> fetch)
//
//   modport master : the fetch unit
//   modport slave  : the environment (ROM + instruction consumer)
// -----------------------------------------------------------------------------
interface instr_fetch_if;
  logic [5:0] rom_addr;
  logic       rom_read;
  logic       rom_ena;
  logic [7:0] rom_data;

  logic [7:0] instr;
  logic [1:0] opcode;
  logic [5:0] operand;
  logic       instr_valid;
  logic       instr_ready;

  logic       jump_en;
  logic [5:0] jump_addr;

  modport master (
    output rom_addr, rom_read, rom_ena,
    input  rom_data,
    output instr, opcode, operand, instr_valid,
    input  instr_ready,
    input  jump_en, jump_addr
  );

  modport slave (
    input  rom_addr, rom_read, rom_ena,
    output rom_data,
    input  instr, opcode, operand, instr_valid,
    output instr_ready,
    output jump_en, jump_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit for a 64-word x 8-bit ROM. Each fetch holds
//   rom_ena/rom_read high for WAIT_CYCLES cycles at rom_addr = pc, captures
//   rom_data on the last of those edges, then presents the word with
//   instr_valid until the consumer takes it (instr_valid && instr_ready).
//   On that handshake pc advances to pc+1, or to jump_addr when jump_en is
//   high. The VALID phase always separates two read windows, so the ROM sees
//   a strobe edge for every fetch.
//
//   Parameters
//     WAIT_CYCLES : ROM access cycles per fetch, 1..7
//     WRAP        : 1 = pc wraps 63 -> 0, 0 = halt in DONE after address 63
//
//   Ports
//     clk   : clock, rising edge
//     rst   : synchronous, active-high reset
//     start : level, enables fetching
//     bus   : instr_fetch_if.master (ROM bus, instruction hand-off, jump)
//     pc    : address of the current / next fetch
//     busy  : high while a fetch is being read or presented
//     done  : high once halted after address 63 (WRAP = 0 only)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          WRAP        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_fetch_if.master         bus,
  output logic [5:0]            pc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index of the final ROM access cycle within a fetch.
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);
  localparam logic [5:0] PC_LAST   = 6'd63;

  state_t     state_q, state_d;
  logic [2:0] wait_q,  wait_d;
  logic [5:0] pc_q,    pc_d;
  logic [7:0] instr_q, instr_d;

  logic       handshake;
  logic       halt_now;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    pc_d            = pc_q;
    instr_d         = instr_q;

    bus.rom_addr    = '0;
    bus.rom_read    = 1'b0;
    bus.rom_ena     = 1'b0;
    bus.instr_valid = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;

    handshake       = 1'b0;
    halt_now        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          wait_d  = '0;
        end
      end

      REQ: begin
        bus.rom_addr = pc_q;
        bus.rom_read = 1'b1;
        bus.rom_ena  = 1'b1;
        busy         = 1'b1;
        // start is deliberately not looked at here: an accepted fetch
        // always completes and is presented.
        if (wait_q == WAIT_LAST) begin
          instr_d = bus.rom_data;
          wait_d  = '0;
          state_d = VALID;
        end else begin
          wait_d  = wait_q + 3'd1;
        end
      end

      VALID: begin
        bus.instr_valid = 1'b1;
        busy            = 1'b1;
        handshake       = bus.instr_ready;
        // Running off the end without a jump halts when wrapping is off;
        // this wins over start. pc is left at 63 while halted.
        halt_now        = !WRAP && (pc_q == PC_LAST) && !bus.jump_en;
        if (handshake) begin
          if (halt_now) begin
            state_d = DONE;
          end else begin
            pc_d    = bus.jump_en ? bus.jump_addr : pc_q + 6'd1;
            state_d = start ? REQ : IDLE;
          end
        end
      end

      DONE: begin
        done = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pc          = pc_q;
  assign bus.instr   = instr_q;
  assign bus.opcode  = instr_q[7:6];
  assign bus.operand = instr_q[5:0];

endmodule
